rng_capture_streamer: RTL and testbench

Parametrised capture-and-stream engine for the ring-oscillator random number generator. It synchronises and samples the combined raw random bit at a fixed divisor of the system clock. Samples are packed MSB-first into a byte-wide buffer, up to a run-time sample count. After capture, the buffer is streamed over a valid/ready byte interface, either as packed binary bytes or as ASCII '0'/'1' characters. It sits between the oscillator XOR and the UART transmitter.

---
 rtl/rng_capture_streamer.sv | 239 +++++++++++++++++++++++
 tb/tb_rng_capture_streamer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_capture_streamer.sv
// Ring-oscillator RNG capture buffer with packed-binary or ASCII byte streaming.
// Define RNG_VON_NEUMANN_EN to debias samples pairwise (01->0, 10->1, 00/11 dropped).
module rng_capture_streamer #(
    parameter int SAMPLE_DIV  = 32,
    parameter int DEPTH_BYTES = 125000,
    parameter int CNT_W       = $clog2(DEPTH_BYTES*8+1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             raw_bit,
    input  logic             start,
    input  logic [CNT_W-1:0] sample_count,
    input  logic             mode,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_o
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int AW    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    localparam logic [CNT_W-1:0] CAP      = CNT_W'(DEPTH_BYTES*8);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV-1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        FLUSH   = 3'd2,
        READ    = 3'd3,
        SEND    = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             mode_q, mode_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             done_q, done_d;
`ifdef RNG_VON_NEUMANN_EN
    logic             pair_q, pair_d;
    logic             a_q, a_d;
`endif

    logic [7:0]       mem [DEPTH_BYTES];
    logic [7:0]       rd_data_q;
    logic             mem_we;
    logic [7:0]       mem_wdata;

    logic             emit;
    logic             smp;
    logic             chr_bit;
    logic [CNT_W:0]   nbytes;

    assign nbytes  = ({1'b0, n_q} + (CNT_W+1)'(7)) >> 3;
    assign chr_bit = rd_data_q[3'd7 - tx_cnt_q[2:0]];

    // Buffer has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= mem_wdata;
        end
        if (state_q == READ) begin
            rd_data_q <= mem[rd_addr_q];
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        n_d        = n_q;
        mode_d     = mode_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        tx_cnt_d   = tx_cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = shift_q;
        emit       = 1'b0;
        smp        = 1'b0;
`ifdef RNG_VON_NEUMANN_EN
        pair_d     = pair_q;
        a_d        = a_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (sample_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        n_d       = (sample_count > CAP) ? CAP : sample_count;
                        mode_d    = mode;
                        div_d     = '0;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        wr_addr_d = '0;
                        rd_addr_d = '0;
                        tx_cnt_d  = '0;
`ifdef RNG_VON_NEUMANN_EN
                        pair_d    = 1'b0;
                        a_d       = 1'b0;
`endif
                        state_d   = CAPTURE;
                    end
                end
            end

            CAPTURE: begin
                div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                if (div_q == DIV_LAST) begin
`ifdef RNG_VON_NEUMANN_EN
                    pair_d = ~pair_q;
                    a_d    = sync2_q;
                    emit   = pair_q && (a_q != sync2_q);
                    smp    = a_q;
`else
                    emit   = 1'b1;
                    smp    = sync2_q;
`endif
                end
                if (emit) begin
                    shift_d   = {shift_q[6:0], smp};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_d[2:0] == 3'd0) begin
                        mem_we    = 1'b1;
                        mem_wdata = shift_d;
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                    if (bit_cnt_d == n_q) begin
                        state_d = (n_q[2:0] != 3'd0) ? FLUSH : READ;
                    end
                end
            end

            FLUSH: begin
                // Left-align the n%8 tail bits: shift by 8 - n%8 (mod 8).
                mem_we    = 1'b1;
                mem_wdata = shift_q << (3'd0 - n_q[2:0]);
                state_d   = READ;
            end

            READ: begin
                state_d = SEND;
            end

            SEND: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = mode_q ? rd_data_q : {7'b0011000, chr_bit};
                end else if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    tx_cnt_d   = tx_cnt_q + CNT_W'(1);
                    if (mode_q) begin
                        if ({1'b0, tx_cnt_d} == nbytes) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            rd_addr_d = rd_addr_q + AW'(1);
                            state_d   = READ;
                        end
                    end else if (tx_cnt_d == n_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (tx_cnt_d[2:0] == 3'd0) begin
                        rd_addr_d = rd_addr_q + AW'(1);
                        state_d   = READ;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            div_q      <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            n_q        <= '0;
            mode_q     <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            tx_cnt_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef RNG_VON_NEUMANN_EN
            pair_q     <= 1'b0;
            a_q        <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= raw_bit;
            sync2_q    <= sync1_q;
            div_q      <= div_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            n_q        <= n_d;
            mode_q     <= mode_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
`ifdef RNG_VON_NEUMANN_EN
            pair_q     <= pair_d;
            a_q        <= a_d;
`endif
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_rng_capture_streamer.sv
// Randomised bench for rng_capture_streamer against a bit-list reference model.
// Builds with or without RNG_VON_NEUMANN_EN; the model follows the same define.
module tb_rng_capture_streamer;

    localparam int D    = 4;
    localparam int DEP  = 4;
    localparam int CAPB = DEP*8;
    localparam int CW   = $clog2(CAPB+1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          raw_bit = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] sample_count = '0;
    logic          mode = 1'b0;
    logic          tx_ready = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          busy;
    logic          done;
    logic [2:0]    state_o;

    int tests = 0;
    int fails = 0;

    bit         raw_q[$];
    bit         exp_bits[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    rng_capture_streamer #(
        .SAMPLE_DIV(D),
        .DEPTH_BYTES(DEP),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .raw_bit(raw_bit),
        .start(start),
        .sample_count(sample_count),
        .mode(mode),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .done(done),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic fill_raws(input int len);
        raw_q.delete();
        for (int i = 0; i < len; i++) raw_q.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic start_run(input bit md, input int cnt);
        start = 1'b1;
        mode = md;
        sample_count = CW'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (state_o !== 3'd1) begin
            fails++;
            $display("FAIL start_to_capture: state_o=%0d want 1", state_o);
        end
    endtask

    // Drives one raw value per strobe window and records the bits the block should keep.
    task automatic feed(input int n_eff);
        int s = 0;
        int emitted = 0;
        bit ok_cap = 1'b1;
        exp_bits.delete();
        while (emitted < n_eff) begin
            if (s >= raw_q.size()) begin
                $display("FAIL feed: raw stimulus exhausted at %0d of %0d bits", emitted, n_eff);
                $fatal(1);
            end
            raw_bit = raw_q[s];
            for (int c = 0; c < D; c++) begin
                if (state_o !== 3'd1) ok_cap = 1'b0;
                @(posedge clk); #1;
            end
`ifdef RNG_VON_NEUMANN_EN
            if ((s % 2 == 1) && (raw_q[s-1] != raw_q[s])) begin
                exp_bits.push_back(raw_q[s-1]);
                emitted++;
            end
`else
            exp_bits.push_back(raw_q[s]);
            emitted++;
`endif
            s++;
        end
        tests++;
        if (!ok_cap) begin
            fails++;
            $display("FAIL capture_duration: left CAPTURE before %0d strobes", s);
        end
        tests++;
        if (state_o !== ((n_eff % 8 != 0) ? 3'd2 : 3'd3)) begin
            fails++;
            $display("FAIL capture_exit: state_o=%0d want %0d", state_o,
                     (n_eff % 8 != 0) ? 2 : 3);
        end
    endtask

    task automatic collect(input int policy, input bit md);
        bit         prev_xfer = 1'b0;
        bit         prev_stall = 1'b0;
        bit         fin = 1'b0;
        bit         gap_bad = 1'b0;
        bit         hold_bad = 1'b0;
        bit         stall_bad = 1'b0;
        bit         stalled = 1'b0;
        logic [7:0] prev_data = '0;
        int         stall_left = 0;
        int         cyc = 0;
        got_q.delete();
        while (!fin && cyc < 4000) begin
            if (done === 1'b1) begin
                fin = 1'b1;
                tests++;
                if (state_o !== 3'd0) begin
                    fails++;
                    $display("FAIL done_state: state_o=%0d want 0 with done", state_o);
                end
            end else begin
                if (prev_xfer && tx_valid !== 1'b0) gap_bad = 1'b1;
                if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) hold_bad = 1'b1;
                if (policy == 0) begin
                    tx_ready = 1'b1;
                end else if (policy == 1) begin
                    tx_ready = 1'($urandom_range(0, 1));
                end else begin
                    if (tx_valid === 1'b1 && !stalled) begin
                        stalled = 1'b1;
                        stall_left = 100;
                    end
                    if (stall_left > 0) begin
                        tx_ready = 1'b0;
                        if (state_o !== 3'd4) stall_bad = 1'b1;
                        start = (stall_left == 50);
                        if (start) begin
                            sample_count = CW'(3);
                            mode = ~md;
                        end
                        stall_left--;
                    end else begin
                        tx_ready = 1'b1;
                        start = 1'b0;
                    end
                end
                prev_xfer = tx_valid && tx_ready;
                prev_stall = tx_valid && !tx_ready;
                prev_data = tx_data;
                if (prev_xfer) got_q.push_back(tx_data);
                @(posedge clk); #1;
                cyc++;
            end
        end
        tx_ready = 1'b0;
        start = 1'b0;
        tests++;
        if (!fin) begin
            fails++;
            $display("FAIL done_timeout: no done after %0d cycles", cyc);
        end
        tests++;
        if (gap_bad) begin
            fails++;
            $display("FAIL valid_gap: tx_valid=1 right after a transfer, want 0");
        end
        tests++;
        if (hold_bad) begin
            fails++;
            $display("FAIL hold: tx_valid/tx_data changed while stalled, want stable");
        end
        if (policy == 2) begin
            tests++;
            if (!stalled || stall_bad) begin
                fails++;
                $display("FAIL stall_start_ignored: stalled=%0d bad=%0d want 1/0", stalled, stall_bad);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: done=%0d busy=%0d want 0/0", done, busy);
        end
    endtask

    task automatic compare(input string name, input bit md);
        logic [7:0] b;
        exp_q.delete();
        if (md) begin
            for (int i = 0; i < exp_bits.size(); i += 8) begin
                b = '0;
                for (int k = 0; k < 8; k++) begin
                    if (i + k < exp_bits.size()) b[7-k] = exp_bits[i+k];
                end
                exp_q.push_back(b);
            end
        end else begin
            foreach (exp_bits[i]) exp_q.push_back(8'h30 + 8'(exp_bits[i]));
        end
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s_len: got %0d bytes want %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL %s_byte%0d: got %h want %h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic run_case(input string name, input bit md, input int cnt, input int policy);
        int n_eff;
        n_eff = (cnt > CAPB) ? CAPB : cnt;
        start_run(md, cnt);
        feed(n_eff);
        collect(policy, md);
        compare(name, md);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({tx_data, tx_valid, busy, done, state_o} !== 14'd0) begin
            fails++;
            $display("FAIL reset_values: data=%h v=%0d busy=%0d done=%0d st=%0d want all 0",
                     tx_data, tx_valid, busy, done, state_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({tx_data, tx_valid, busy, done, state_o} !== 14'd0) begin
            fails++;
            $display("FAIL after_reset: data=%h v=%0d busy=%0d done=%0d st=%0d want all 0",
                     tx_data, tx_valid, busy, done, state_o);
        end
    endtask

    task automatic test_zero_count();
        start = 1'b1;
        sample_count = '0;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || state_o !== 3'd0) begin
            fails++;
            $display("FAIL zero_count: done=%0d st=%0d want 1/0", done, state_o);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL zero_count_pulse: done=%0d want 0", done);
        end
    endtask

    task automatic test_random(input int runs);
        int cnt;
        bit md;
        for (int r = 0; r < runs; r++) begin
            cnt = $urandom_range(1, CAPB);
            md = 1'($urandom_range(0, 1));
            fill_raws(400);
            run_case("random", md, cnt, 1);
        end
    endtask

    task automatic test_backpressure();
        fill_raws(400);
        run_case("backpressure", 1'b1, 20, 2);
    endtask

    task automatic test_clamp();
        fill_raws(400);
        run_case("clamp", 1'b1, CAPB + 5, 1);
        tests++;
        if (got_q.size() != DEP) begin
            fails++;
            $display("FAIL clamp_bytes: got %0d want %0d", got_q.size(), DEP);
        end
    endtask

    task automatic test_reset_mid_send();
        int cyc = 0;
        fill_raws(400);
        start_run(1'b1, 8);
        feed(8);
        tx_ready = 1'b0;
        while (tx_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (tx_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_send_reach: tx_valid=%0d want 1", tx_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (tx_valid !== 1'b0 || state_o !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: v=%0d st=%0d busy=%0d done=%0d want 0",
                     tx_valid, state_o, busy, done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if ({tx_data, tx_valid, busy, done, state_o} !== 14'd0) cyc = -1000;
        end
        tests++;
        if (cyc < 0) begin
            fails++;
            $display("FAIL post_reset_quiet: an output went nonzero, want all 0");
        end
    endtask

`ifdef RNG_VON_NEUMANN_EN
    task automatic test_von_neumann();
        bit pat[24] = '{0,1, 1,0, 0,0, 1,1, 1,0, 0,1, 0,1, 1,0, 1,1, 1,0, 0,0, 0,1};
        raw_q.delete();
        foreach (pat[i]) raw_q.push_back(pat[i]);
        run_case("vn_fixed", 1'b1, 8, 0);
        tests++;
        if (got_q.size() < 1 || got_q[0] !== 8'h66) begin
            fails++;
            $display("FAIL vn_fixed_byte: got %h want 66", (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
    endtask
`else
    task automatic test_packed();
        raw_q.delete();
        for (int i = 0; i < 16; i++) raw_q.push_back(1'b1);
        run_case("packed16", 1'b1, 16, 0);
        tests++;
        if (got_q.size() != 2 || got_q[0] !== 8'hFF || got_q[1] !== 8'hFF) begin
            fails++;
            $display("FAIL packed16_const: got %0d bytes, want FF FF", got_q.size());
        end
    endtask

    task automatic test_partial();
        raw_q.delete();
        for (int i = 0; i < 12; i++) raw_q.push_back(1'b1);
        run_case("partial12", 1'b1, 12, 0);
        tests++;
        if (got_q.size() != 2 || got_q[0] !== 8'hFF || got_q[1] !== 8'hF0) begin
            fails++;
            $display("FAIL partial12_const: got %0d bytes, want FF F0", got_q.size());
        end
    endtask

    task automatic test_ascii();
        raw_q.delete();
        for (int i = 0; i < 10; i++) raw_q.push_back(1'((i + 1) % 2));
        run_case("ascii10", 1'b0, 10, 0);
        tests++;
        if (got_q.size() != 10 || got_q[0] !== 8'h31 || got_q[9] !== 8'h30) begin
            fails++;
            $display("FAIL ascii10_const: got %0d chars, want 31..30", got_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_count();
`ifdef RNG_VON_NEUMANN_EN
        test_von_neumann();
`else
        test_packed();
        test_partial();
        test_ascii();
`endif
        test_backpressure();
        test_clamp();
        test_random(6);
        test_reset_mid_send();
        test_random(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
